// File: rtl/digit_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : digit_serializer_pkg
//  Purpose  : Shared constants, state encoding and per-base digit geometry
//             for the digit serializer and its shift register.
//  Contents : BASE_* encodings, state_t, digit_width(), digit_count()
//  Revision : 1.0  initial release
// ============================================================================
package digit_serializer_pkg;

   localparam logic [1:0] BASE_BIN = 2'b00;
   localparam logic [1:0] BASE_OCT = 2'b01;
   localparam logic [1:0] BASE_HEX = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   // Bits per digit for a captured base code (reserved 11 behaves as hex).
   function automatic int unsigned digit_width(input logic [1:0] base);
      case (base)
         BASE_BIN: return 1;
         BASE_OCT: return 3;
         default:  return 4;
      endcase
   endfunction

   // Digits needed to cover a data_w-bit operand in the given base.
   function automatic int unsigned digit_count(input int unsigned data_w,
                                               input logic [1:0]  base);
      return data_w / digit_width(base);
   endfunction

endpackage : digit_serializer_pkg
`default_nettype wire

// File: rtl/digit_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : digit_shift_reg
//  Purpose  : DATA_W-bit loadable left-shift register; shift distance is the
//             digit width of the selected base (1, 3 or 4), zero fill.
//  Ports    : clk, rst (async, active-high)
//             load / load_data  : parallel load (has priority over shift)
//             shift / shift_sel : shift left by digit_width(shift_sel)
//             data              : current register contents
//  Revision : 1.0  initial release
// ============================================================================
module digit_shift_reg
   import digit_serializer_pkg::*;
#(
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              shift,
   input  logic [1:0]        shift_sel,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = load_data;
      end else if (shift) begin
         case (shift_sel)
            BASE_BIN: data_d = data_q << 1;
            BASE_OCT: data_d = data_q << 3;
            default:  data_d = data_q << 4;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data = data_q;

endmodule : digit_shift_reg
`default_nettype wire

// File: rtl/digit_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : digit_serializer
//  Purpose  : Captures one DATA_W-bit operand and drains it one digit per
//             valid/ready handshake, MSD first, in binary, octal or hex.
//  Ports    : clk, rst (async, active-high)
//             load_valid/load_ready, data_in, base_sel : operand capture
//             digit, digit_valid, digit_ready          : digit stream
//             digit_last, digit_index                  : stream position
//  Notes    : DATA_W must be a multiple of 12; 2**CNT_W >= DATA_W.
//  Revision : 1.0  initial release
// ============================================================================
module digit_serializer
   import digit_serializer_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [1:0]        base_sel,
   output logic [3:0]        digit,
   output logic              digit_valid,
   input  logic              digit_ready,
   output logic              digit_last,
   output logic [CNT_W-1:0]  digit_index
);

   // Starting index (digit count - 1) for each base.
   localparam logic [CNT_W-1:0] IDX_BIN = CNT_W'(digit_count(DATA_W, BASE_BIN) - 1);
   localparam logic [CNT_W-1:0] IDX_OCT = CNT_W'(digit_count(DATA_W, BASE_OCT) - 1);
   localparam logic [CNT_W-1:0] IDX_HEX = CNT_W'(digit_count(DATA_W, BASE_HEX) - 1);

   state_t            state_q, state_d;
   logic [1:0]        base_q, base_d;
   logic [CNT_W-1:0]  index_q, index_d;
   logic              sr_load;
   logic              sr_shift;
   logic [DATA_W-1:0] sr_data;
   logic [1:0]        base_cap;
   logic [3:0]        digit_raw;
   logic              handshake;

   // Reserved code 11 is folded into hex at capture so every later decode
   // only ever sees the three legal bases.
   assign base_cap = (base_sel == 2'b11) ? BASE_HEX : base_sel;

   assign digit_valid = (state_q == ST_EMIT);
   assign load_ready  = (state_q == ST_IDLE);
   assign handshake   = digit_valid && digit_ready;
   assign digit_index = index_q;
   assign digit_last  = digit_valid && (index_q == '0);

   digit_shift_reg #(
      .DATA_W (DATA_W)
   ) u_shift_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (sr_load),
      .load_data (data_in),
      .shift     (sr_shift),
      .shift_sel (base_q),
      .data      (sr_data)
   );

   // The current digit always sits in the top bits of the shift register.
   always_comb begin
      case (base_q)
         BASE_BIN: digit_raw = {3'b000, sr_data[DATA_W-1]};
         BASE_OCT: digit_raw = {1'b0, sr_data[DATA_W-1 -: 3]};
         default:  digit_raw = sr_data[DATA_W-1 -: 4];
      endcase
   end

   // Masked outside EMIT so stale register contents never reach the output.
   assign digit = digit_valid ? digit_raw : 4'h0;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      index_d  = index_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_valid) begin
               sr_load = 1'b1;
               base_d  = base_cap;
               state_d = ST_EMIT;
               case (base_cap)
                  BASE_BIN: index_d = IDX_BIN;
                  BASE_OCT: index_d = IDX_OCT;
                  default:  index_d = IDX_HEX;
               endcase
            end
         end
         ST_EMIT: begin
            if (handshake) begin
               if (index_q == '0) begin
                  // Final digit taken; index already rests at 0 for IDLE.
                  state_d = ST_IDLE;
               end else begin
                  sr_shift = 1'b1;
                  index_d  = index_q - 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         base_q  <= BASE_BIN;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         index_q <= index_d;
      end
   end

endmodule : digit_serializer
`default_nettype wire
